// File: rtl/mcs_pcstack.sv
// MCS8 program-counter / return-address stack: single clock, parametrised
// width and depth, conditional jump/call/return, RST vectors, overflow/underflow.
module mcs_pcstack #(
  parameter int AW    = 14,
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int WRAP  = 1
) (
  input  logic                     CLK_I,
  input  logic                     nRST_I,
  input  logic                     LD_LO_I,
  input  logic                     LD_HI_I,
  input  logic [DW-1:0]            LD_DAT_I,
  input  logic                     JMP_I,
  input  logic                     CALL_I,
  input  logic                     RET_I,
  input  logic                     RST_I,
  input  logic [2:0]               VEC_I,
  input  logic                     COND_I,
  input  logic                     INCR_I,
  input  logic                     RD_HI_I,
  output logic [AW-1:0]            PC_O,
  output logic [DW-1:0]            DAT_O,
  output logic [$clog2(DEPTH)-1:0] LVL_O,
  output logic                     OVF_O,
  output logic                     UNF_O
);

  localparam int PW = $clog2(DEPTH);
  localparam int HW = AW - DW;

  if (DW >= AW || AW > 2 * DW) begin : g_bad_aw
    $error("mcs_pcstack: AW must satisfy DW < AW <= 2*DW");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mcs_pcstack: DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [2:0] {OP_NONE, OP_INCR, OP_JMP, OP_CALL, OP_RET, OP_RST} op_e;

  logic [AW-1:0] stack_q [DEPTH];
  logic [AW-1:0] stack_d [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] lvl_q, lvl_d;
  logic [AW-1:0] tgt_q, tgt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  op_e           op;
  logic          full, empty;
  logic [AW-1:0] push_val;

  // Fixed priority; a conditional op with COND_I low falls through to lower ones.
  always_comb begin
    if (RST_I)                 op = OP_RST;
    else if (CALL_I && COND_I) op = OP_CALL;
    else if (JMP_I && COND_I)  op = OP_JMP;
    else if (RET_I && COND_I)  op = OP_RET;
    else if (INCR_I)           op = OP_INCR;
    else                       op = OP_NONE;
  end

  assign full     = (lvl_q == PW'(DEPTH - 1));
  assign empty    = (lvl_q == '0);
  assign push_val = (op == OP_RST) ? AW'({VEC_I, 3'b000}) : tgt_q;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so later statements override cleanly and no latch is inferred.
  always_comb begin
    stack_d = stack_q;
    ptr_d   = ptr_q;
    lvl_d   = lvl_q;
    tgt_d   = tgt_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;

    if (LD_LO_I) tgt_d[DW-1:0] = LD_DAT_I;
    if (LD_HI_I) tgt_d[AW-1:DW] = LD_DAT_I[HW-1:0];

    unique case (op)
      OP_INCR: stack_d[ptr_q] = stack_q[ptr_q] + AW'(1);
      OP_JMP:  stack_d[ptr_q] = tgt_q;
      OP_CALL, OP_RST: begin
        ovf_d = full;
        // In wrap mode a full push advances onto the oldest entry and overwrites it.
        if (!full || WRAP != 0) begin
          ptr_d          = ptr_q + PW'(1);
          stack_d[ptr_d] = push_val;
          if (!full) lvl_d = lvl_q + PW'(1);
        end
      end
      OP_RET: begin
        unf_d = empty;
        if (!empty || WRAP != 0) begin
          ptr_d = ptr_q - PW'(1);
          if (!empty) lvl_d = lvl_q - PW'(1);
        end
      end
      default: ;
    endcase
  end

  // NOTE: the stack array is reset along with the pointer so PC_O reads 0
  // asynchronously; sequential blocks use non-blocking '<=' only.
  always_ff @(posedge CLK_I or negedge nRST_I) begin
    if (!nRST_I) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      ptr_q <= '0;
      lvl_q <= '0;
      tgt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
      ptr_q <= ptr_d;
      lvl_q <= lvl_d;
      tgt_q <= tgt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign PC_O  = stack_q[ptr_q];
  assign DAT_O = RD_HI_I ? DW'(PC_O[AW-1:DW]) : PC_O[DW-1:0];
  assign LVL_O = lvl_q;
  assign OVF_O = ovf_q;
  assign UNF_O = unf_q;

endmodule

// File: tb/tb_mcs_pcstack.sv
// Directed bench for mcs_pcstack: a wrapping and a saturating instance share
// stimulus; expected states are queued per step and compared after the edge.
module tb_mcs_pcstack;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        rst_n;
  logic        ld_lo, ld_hi, jmp, call, ret, rst, cond, incr, rd_hi;
  logic [7:0]  ld_dat;
  logic [2:0]  vec;

  logic [13:0] pc_w, pc_s;
  logic [7:0]  dat_w, dat_s;
  logic [2:0]  lvl_w, lvl_s;
  logic        ovf_w, ovf_s, unf_w, unf_s;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    bit          sat;
    logic [13:0] pc;
    logic [2:0]  lvl;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb[$];

  mcs_pcstack #(.AW(14), .DW(8), .DEPTH(8), .WRAP(1)) u_wrap (
    .CLK_I(clk), .nRST_I(rst_n), .LD_LO_I(ld_lo), .LD_HI_I(ld_hi), .LD_DAT_I(ld_dat),
    .JMP_I(jmp), .CALL_I(call), .RET_I(ret), .RST_I(rst), .VEC_I(vec), .COND_I(cond),
    .INCR_I(incr), .RD_HI_I(rd_hi), .PC_O(pc_w), .DAT_O(dat_w), .LVL_O(lvl_w),
    .OVF_O(ovf_w), .UNF_O(unf_w)
  );

  mcs_pcstack #(.AW(14), .DW(8), .DEPTH(8), .WRAP(0)) u_sat (
    .CLK_I(clk), .nRST_I(rst_n), .LD_LO_I(ld_lo), .LD_HI_I(ld_hi), .LD_DAT_I(ld_dat),
    .JMP_I(jmp), .CALL_I(call), .RET_I(ret), .RST_I(rst), .VEC_I(vec), .COND_I(cond),
    .INCR_I(incr), .RD_HI_I(rd_hi), .PC_O(pc_s), .DAT_O(dat_s), .LVL_O(lvl_s),
    .OVF_O(ovf_s), .UNF_O(unf_s)
  );

  always #5 if (clk_en) clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_strobes();
    ld_lo = 0; ld_hi = 0; jmp = 0; call = 0; ret = 0; rst = 0; cond = 0; incr = 0;
  endtask

  // Queue the state expected after the coming edge, clock it, then drain the queue.
  task automatic step(input string tag, input logic [13:0] pc, input logic [2:0] lvl,
                      input logic ovf = 1'b0, input logic unf = 1'b0, input bit sat = 1'b0);
    exp_t e;
    e.tag = tag; e.sat = sat; e.pc = pc; e.lvl = lvl; e.ovf = ovf; e.unf = unf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    clear_strobes();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sat) begin
        check({e.tag, " pc"},  32'(pc_s),  32'(e.pc));
        check({e.tag, " lvl"}, 32'(lvl_s), 32'(e.lvl));
        check({e.tag, " ovf"}, 32'(ovf_s), 32'(e.ovf));
        check({e.tag, " unf"}, 32'(unf_s), 32'(e.unf));
      end else begin
        check({e.tag, " pc"},  32'(pc_w),  32'(e.pc));
        check({e.tag, " lvl"}, 32'(lvl_w), 32'(e.lvl));
        check({e.tag, " ovf"}, 32'(ovf_w), 32'(e.ovf));
        check({e.tag, " unf"}, 32'(unf_w), 32'(e.unf));
      end
    end
  endtask

  initial begin
    clear_strobes();
    ld_dat = '0; vec = '0; rd_hi = 0;
    rst_n = 0;
    #1;
    check("reset pc", 32'(pc_w), 32'h0);
    check("reset dat", 32'(dat_w), 32'h0);
    check("reset lvl", 32'(lvl_w), 32'h0);
    check("reset ovf", 32'(ovf_w), 32'h0);
    check("reset unf", 32'(unf_w), 32'h0);
    #2 rst_n = 1;

    // Increment and byte readback
    for (int i = 1; i <= 3; i++) begin
      incr = 1; step($sformatf("incr%0d", i), 14'(i), 3'd0);
    end
    check("dat lo 0x0003", 32'(dat_w), 32'h03);
    rd_hi = 1; #1;
    check("dat hi 0x0003", 32'(dat_w), 32'h00);
    rd_hi = 0;

    ld_lo = 1; ld_hi = 1; ld_dat = 8'hFF; step("load ff", 14'h0003, 3'd0);
    ld_hi = 1; ld_dat = 8'h3F;            step("load 3f", 14'h0003, 3'd0);
    jmp = 1; cond = 1;                    step("jmp 3fff", 14'h3FFF, 3'd0);
    rd_hi = 1; #1;
    check("dat hi 0x3fff", 32'(dat_w), 32'h3F);
    rd_hi = 0; #1;
    check("dat lo 0x3fff", 32'(dat_w), 32'hFF);
    incr = 1;                             step("incr wrap", 14'h0000, 3'd0);
    for (int i = 1; i <= 3; i++) begin
      incr = 1; step("incr again", 14'(i), 3'd0);
    end

    // Call / return
    ld_lo = 1; ld_dat = 8'h34;            step("load 34", 14'h0003, 3'd0);
    ld_hi = 1; ld_dat = 8'hD2;            step("load d2", 14'h0003, 3'd0);
    call = 1; cond = 1;                   step("call 1234", 14'h1234, 3'd1);
    ret = 1; cond = 1;                    step("ret", 14'h0003, 3'd0);

    // Failed conditions fall through; RST is unconditional
    call = 1; incr = 1; cond = 0;         step("call nc+incr", 14'h0004, 3'd0);
    jmp = 1; ret = 1; incr = 1; cond = 0; step("jmp ret nc+incr", 14'h0005, 3'd0);
    rst = 1; vec = 3'd5; cond = 0;        step("rst vec5", 14'h0028, 3'd1);
    ret = 1; cond = 1;                    step("ret from rst", 14'h0005, 3'd0);

    // Latch update is seen only by the next op
    ld_lo = 1; ld_dat = 8'h55; jmp = 1; cond = 1; step("jmp pre-load", 14'h1234, 3'd0);
    jmp = 1; cond = 1;                    step("jmp post-load", 14'h1255, 3'd0);
    rst = 1; vec = 3'd2; call = 1; jmp = 1; cond = 1; step("rst beats call", 14'h0010, 3'd1);
    ret = 1; cond = 1;                    step("ret to 1255", 14'h1255, 3'd0);

    // Wrap-mode overflow and underflow
    ld_lo = 1; ld_hi = 1; ld_dat = 8'h10; #0 ld_hi = 0;
    step("load 0010", 14'h1255, 3'd0);
    ld_hi = 1; ld_dat = 8'h02;            step("load 02", 14'h1255, 3'd0);
    for (int i = 0; i < 8; i++) begin
      call = 1; cond = 1; ld_lo = 1; ld_dat = 8'(8'h11 + i);
      step($sformatf("wrap call%0d", i), 14'(14'h0210 + i), 3'(i < 7 ? i + 1 : 7), i == 7);
    end
    for (int k = 1; k <= 8; k++) begin
      ret = 1; cond = 1;
      if (k < 8) step($sformatf("wrap ret%0d", k), 14'(14'h0217 - k), 3'(7 - k));
      else       step("wrap ret8", 14'h0217, 3'd0, 1'b0, 1'b1);
    end
    step("wrap idle", 14'h0217, 3'd0);

    // Saturating instance, after a mid-cycle asynchronous reset
    rst_n = 0; #1;
    check("sat async reset pc", 32'(pc_s), 32'h0);
    #1 rst_n = 1;
    ld_lo = 1; ld_hi = 1; ld_dat = 8'h03; step("sat load", 14'h0000, 3'd0, 1'b0, 1'b0, 1'b1);
    ld_lo = 1; ld_dat = 8'h00;            step("sat load lo", 14'h0000, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      call = 1; cond = 1; ld_lo = 1; ld_dat = 8'(i + 1);
      if (i < 7) step($sformatf("sat call%0d", i), 14'(14'h0300 + i), 3'(i + 1), 1'b0, 1'b0, 1'b1);
      else       step("sat call7", 14'h0306, 3'd7, 1'b1, 1'b0, 1'b1);
    end
    for (int k = 1; k <= 7; k++) begin
      ret = 1; cond = 1;
      step($sformatf("sat ret%0d", k), (k < 7) ? 14'(14'h0306 - k) : 14'h0000, 3'(7 - k),
           1'b0, 1'b0, 1'b1);
    end
    incr = 1;                             step("sat incr", 14'h0001, 3'd0, 1'b0, 1'b0, 1'b1);
    ret = 1; cond = 1;                    step("sat ret empty", 14'h0001, 3'd0, 1'b0, 1'b1, 1'b1);
    step("sat idle", 14'h0001, 3'd0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset with the clock stopped
    rst_n = 0; #1 rst_n = 1;
    ld_lo = 1; ld_hi = 1; ld_dat = 8'h0A; step("load 0a", 14'h0000, 3'd0);
    ld_lo = 1; ld_dat = 8'hBC;            step("load bc", 14'h0000, 3'd0);
    for (int i = 1; i <= 3; i++) begin
      call = 1; cond = 1; step($sformatf("deep call%0d", i), 14'h0ABC, 3'(i));
    end
    @(negedge clk);
    clk_en = 0;
    #3 rst_n = 0;
    #1;
    check("stopped reset pc", 32'(pc_w), 32'h0);
    check("stopped reset lvl", 32'(lvl_w), 32'h0);
    check("stopped reset dat", 32'(dat_w), 32'h0);
    #10 rst_n = 1;
    #1 incr = 1;
    clk_en = 1;
    step("post-reset incr", 14'h0001, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
